pipe_ctrl_sequencer: RTL and testbench

//  Sequences the 4-stage control pipeline (ID/EX, EX/MEM, MEM/WB) behind the opcode decoder.

---
 rtl/pipe_ctrl_pkg.sv | 49 ++++
 rtl/pipe_ctrl_sequencer_hazard.sv | 19 +
 rtl/pipe_ctrl_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pipe_ctrl_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the control-pipeline sequencer: opcodes, control-word
// bit positions, redirect-source codes and the sequencer FSM state type.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_JR   = 4'd4;
    localparam logic [3:0] OP_JMEM = 4'd5;
    localparam logic [3:0] OP_BRZ  = 4'd6;
    localparam logic [3:0] OP_BRN  = 4'd7;

    localparam int EX_W  = 5;
    localparam int MEM_W = 7;
    localparam int WB_W  = 3;
    localparam int REG_W = 6;

    // EX word: {ALUOP[2:0], MemRead, MemWrite}
    localparam int EX_MEMWRITE = 0;
    localparam int EX_MEMREAD  = 1;
    localparam int EX_ALUOP_LO = 2;
    localparam int EX_ALUOP_HI = 4;

    // MEM word: {RegWrite, MemToReg, PCtoReg, Jump, JumpMem, BranchN, BranchZ}
    localparam int MEM_BRANCHZ  = 0;
    localparam int MEM_BRANCHN  = 1;
    localparam int MEM_JUMPMEM  = 2;
    localparam int MEM_JUMP     = 3;
    localparam int MEM_PCTOREG  = 4;
    localparam int MEM_MEMTOREG = 5;
    localparam int MEM_REGWRITE = 6;

    localparam logic [1:0] RSRC_NONE   = 2'b00;
    localparam logic [1:0] RSRC_JUMP   = 2'b01;
    localparam logic [1:0] RSRC_JMEM   = 2'b10;
    localparam logic [1:0] RSRC_BRANCH = 2'b11;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } seq_state_t;

    // An instruction in MEM touches data memory if it loads, stores or jumps via memory.
    function automatic logic uses_dmem(input logic [1:0] rw, input logic [MEM_W-1:0] mem_ctl);
        return rw[1] | rw[0] | mem_ctl[MEM_JUMPMEM];
    endfunction

endpackage

// File: rtl/pipe_ctrl_sequencer_hazard.sv
// Load-use detector: the instruction in EX is a load whose destination is a
// source of the valid instruction in ID.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_vld,
    input  logic             ex_memread,
    input  logic             id_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             stall_ld
);

    // Register 0 is compared like any other register.
    assign stall_ld = ex_vld & ex_memread & id_valid &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Control-pipeline sequencer: carries decoder control words through ID/EX,
// EX/MEM and MEM/WB, handles memory freeze, redirects and load-use stalls.
module pipe_ctrl_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [EX_W-1:0]   id_ex_ctl,
    input  logic [MEM_W-1:0]  id_mem_ctl,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              ex_z,
    input  logic              ex_n,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [EX_W-1:0]   ex_ctl_q,
    output logic [MEM_W-1:0]  exmem_ctl_q,
    output logic [1:0]        exmem_rw_q,
    output logic [WB_W-1:0]   wb_ctl_q,
    output logic [REG_W-1:0]  wb_rd_q,
    output logic              redirect,
    output logic [1:0]        redirect_src,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_t        state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic              vld_p0;
    logic [EX_W-1:0]   ex_ctl_p0;
    logic [MEM_W-1:0]  mem_ctl_p0;
    logic [REG_W-1:0]  rd_p0;

    logic              vld_p1;
    logic [1:0]        rw_p1;
    logic [MEM_W-1:0]  mem_ctl_p1;
    logic [REG_W-1:0]  rd_p1;
    logic              z_p1;
    logic              n_p1;

    logic [WB_W-1:0]   wb_ctl_p2;
    logic [REG_W-1:0]  rd_p2;

    logic mem_pend, freeze, stall_ld, ld_stall;
    logic take_jump, take_jmem, take_br;

    function automatic logic [CNT_W-1:0] sat_inc_stall(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WCNT_W-1:0] sat_inc_wait(input logic [WCNT_W-1:0] v);
        return (v >= WCNT_W'(MEM_TIMEOUT)) ? v : v + WCNT_W'(1);
    endfunction

    pipe_hazard_detect u_hazard (
        .ex_vld     (vld_p0),
        .ex_memread (ex_ctl_p0[EX_MEMREAD]),
        .id_valid   (id_valid),
        .ex_rd      (rd_p0),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .stall_ld   (stall_ld)
    );

    // Priority: memory freeze, then redirect, then load-use, else advance.
    assign mem_pend  = vld_p1 & uses_dmem(rw_p1, mem_ctl_p1);
    assign freeze    = mem_pend & ~mem_ready;
    assign take_jump = vld_p1 & ~freeze & mem_ctl_p1[MEM_JUMP];
    assign take_jmem = vld_p1 & ~freeze & mem_ctl_p1[MEM_JUMPMEM] & mem_ready;
    assign take_br   = vld_p1 & ~freeze &
                       ((mem_ctl_p1[MEM_BRANCHZ] & z_p1) | (mem_ctl_p1[MEM_BRANCHN] & n_p1));
    assign redirect  = take_jump | take_jmem | take_br;
    assign ld_stall  = stall_ld & ~freeze & ~redirect;

    assign pc_write   = ~(freeze | ld_stall);
    assign ifid_write = ~(freeze | ld_stall);
    assign ifid_flush = redirect;

    always_comb begin
        redirect_src = RSRC_NONE;
        if (take_jump)
            redirect_src = RSRC_JUMP;
        else if (take_jmem)
            redirect_src = RSRC_JMEM;
        else if (take_br)
            redirect_src = RSRC_BRANCH;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            ST_RUN:      if (freeze) state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ready) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
        // Counts every not-ready cycle of the access, including the entry cycle.
        if (state_nxt == ST_MEM_WAIT)
            wait_cnt_nxt = sat_inc_wait(wait_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
            vld_p0     <= 1'b0;
            ex_ctl_p0  <= '0;
            mem_ctl_p0 <= '0;
            rd_p0      <= '0;
            vld_p1     <= 1'b0;
            rw_p1      <= '0;
            mem_ctl_p1 <= '0;
            rd_p1      <= '0;
            z_p1       <= 1'b0;
            n_p1       <= 1'b0;
            wb_ctl_p2  <= '0;
            rd_p2      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if ((state_nxt == ST_MEM_WAIT) && (wait_cnt_nxt == WCNT_W'(MEM_TIMEOUT)))
                mem_err <= 1'b1;
            if (!pc_write)
                stall_cnt <= sat_inc_stall(stall_cnt);

            if (freeze) begin
                // ID/EX and EX/MEM hold; WB sees a bubble.
                wb_ctl_p2 <= '0;
                rd_p2     <= '0;
            end else begin
                // ---- EX/MEM -> MEM/WB ----
                wb_ctl_p2 <= {mem_ctl_p1[MEM_REGWRITE], mem_ctl_p1[MEM_MEMTOREG],
                              mem_ctl_p1[MEM_PCTOREG]};
                rd_p2     <= rd_p1;
                if (redirect) begin
                    vld_p1     <= 1'b0;
                    rw_p1      <= '0;
                    mem_ctl_p1 <= '0;
                    rd_p1      <= '0;
                    z_p1       <= 1'b0;
                    n_p1       <= 1'b0;
                    vld_p0     <= 1'b0;
                    ex_ctl_p0  <= '0;
                    mem_ctl_p0 <= '0;
                    rd_p0      <= '0;
                end else begin
                    // ---- ID/EX -> EX/MEM ----
                    vld_p1     <= vld_p0;
                    rw_p1      <= {ex_ctl_p0[EX_MEMREAD], ex_ctl_p0[EX_MEMWRITE]};
                    mem_ctl_p1 <= mem_ctl_p0;
                    rd_p1      <= rd_p0;
                    z_p1       <= ex_z;
                    n_p1       <= ex_n;
                    // ---- ID -> ID/EX ----
                    if (ld_stall) begin
                        vld_p0     <= 1'b0;
                        ex_ctl_p0  <= '0;
                        mem_ctl_p0 <= '0;
                        rd_p0      <= '0;
                    end else begin
                        vld_p0     <= id_valid;
                        ex_ctl_p0  <= id_valid ? id_ex_ctl  : '0;
                        mem_ctl_p0 <= id_valid ? id_mem_ctl : '0;
                        rd_p0      <= id_valid ? id_rd      : '0;
                    end
                end
            end
        end
    end

    assign ex_ctl_q    = ex_ctl_p0;
    assign exmem_ctl_q = mem_ctl_p1;
    assign exmem_rw_q  = rw_p1;
    assign wb_ctl_q    = wb_ctl_p2;
    assign wb_rd_q     = rd_p2;

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Scoreboard bench for pipe_ctrl_sequencer: stimulus queues per-cycle expected
// output fields, a negedge monitor pops and compares them.
module tb_pipe_ctrl_sequencer;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    localparam int EX_LW = 'h02, EX_ADD = 'h04, EX_SW = 'h01, EX_BR = 'h08, EX_JMP = 'h00;
    localparam int MC_LW = 'h60, MC_ADD = 'h40, MC_SW = 'h00, MC_BRZ = 'h01, MC_BRN = 'h02;
    localparam int MC_JMP = 'h18, MC_JMEM = 'h04;

    localparam int F_PCW = 0, F_IFW = 1, F_FLUSH = 2, F_RED = 3, F_SRC = 4, F_ERR = 5;
    localparam int F_EXC = 6, F_MEMC = 7, F_RW = 8, F_WBC = 9, F_WBRD = 10, F_STALL = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic id_valid = 1'b0;
    logic [4:0] id_ex_ctl = '0;
    logic [6:0] id_mem_ctl = '0;
    logic [5:0] id_rd = '0, id_rs = '0, id_rt = '0;
    logic ex_z = 1'b0, ex_n = 1'b0, mem_ready = 1'b1;
    logic pc_write, ifid_write, ifid_flush, redirect, mem_err;
    logic [4:0] ex_ctl_q;
    logic [6:0] exmem_ctl_q;
    logic [1:0] exmem_rw_q, redirect_src;
    logic [2:0] wb_ctl_q;
    logic [5:0] wb_rd_q;
    logic [CNT_W-1:0] stall_cnt;

    pipe_ctrl_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex_ctl(id_ex_ctl),
        .id_mem_ctl(id_mem_ctl), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .ex_z(ex_z), .ex_n(ex_n), .mem_ready(mem_ready), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ex_ctl_q(ex_ctl_q),
        .exmem_ctl_q(exmem_ctl_q), .exmem_rw_q(exmem_rw_q), .wb_ctl_q(wb_ctl_q),
        .wb_rd_q(wb_rd_q), .redirect(redirect), .redirect_src(redirect_src),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic int actual(input int f);
        case (f)
            F_PCW:   return int'(pc_write);
            F_IFW:   return int'(ifid_write);
            F_FLUSH: return int'(ifid_flush);
            F_RED:   return int'(redirect);
            F_SRC:   return int'(redirect_src);
            F_ERR:   return int'(mem_err);
            F_EXC:   return int'(ex_ctl_q);
            F_MEMC:  return int'(exmem_ctl_q);
            F_RW:    return int'(exmem_rw_q);
            F_WBC:   return int'(wb_ctl_q);
            F_WBRD:  return int'(wb_rd_q);
            F_STALL: return int'(stall_cnt);
            default: return -1;
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: cycle %0d not sampled, now at cycle %0d", e.name, e.cyc, cyc);
            end else if (actual(e.fld) != e.val) begin
                errors = errors + 1;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, actual(e.fld), e.val, cyc);
            end
        end
    end

    task automatic want(input string name, input int f, input int val);
        exp_t e;
        e.cyc  = cyc;
        e.fld  = f;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic drive(input int v, input int ex, input int mc, input int rd, input int rs,
                         input int rt, input int z, input int n, input int rdy, input int rst);
        @(posedge clk);
        #1;
        id_valid   = 1'(v);
        id_ex_ctl  = 5'(ex);
        id_mem_ctl = 7'(mc);
        id_rd      = 6'(rd);
        id_rs      = 6'(rs);
        id_rt      = 6'(rt);
        ex_z       = 1'(z);
        ex_n       = 1'(n);
        mem_ready  = 1'(rdy);
        reset      = 1'(rst);
    endtask

    task automatic ins(input int ex, input int mc, input int rd, input int rs, input int rt);
        drive(1, ex, mc, rd, rs, rt, 0, 0, 1, 0);
    endtask

    task automatic idle(input int rdy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic rst_cycle(input int rdy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, rdy, 1);
    endtask

    task automatic want_reset_state(input string p);
        want({p, "_pcw"}, F_PCW, 1);
        want({p, "_ifw"}, F_IFW, 1);
        want({p, "_flush"}, F_FLUSH, 0);
        want({p, "_redirect"}, F_RED, 0);
        want({p, "_src"}, F_SRC, 0);
        want({p, "_mem_err"}, F_ERR, 0);
        want({p, "_stall_cnt"}, F_STALL, 0);
        want({p, "_ex_ctl"}, F_EXC, 0);
        want({p, "_exmem_ctl"}, F_MEMC, 0);
        want({p, "_exmem_rw"}, F_RW, 0);
        want({p, "_wb_ctl"}, F_WBC, 0);
        want({p, "_wb_rd"}, F_WBRD, 0);
    endtask

    initial begin
        rst_cycle(1);
        idle(1);
        want_reset_state("rst");

        // Load-use: LW r5 in EX, consumer reads r5
        rst_cycle(1);
        ins(EX_LW, MC_LW, 5, 1, 2);
        ins(EX_ADD, MC_ADD, 7, 5, 3);
        want("lu_pcw", F_PCW, 0);
        want("lu_ifw", F_IFW, 0);
        want("lu_ex_ctl", F_EXC, EX_LW);
        want("lu_stall0", F_STALL, 0);
        ins(EX_ADD, MC_ADD, 7, 5, 3);
        want("lu_bubble", F_EXC, 0);
        want("lu_resume", F_PCW, 1);
        want("lu_stall1", F_STALL, 1);
        want("lu_rw", F_RW, 2);
        idle(1);
        want("lu_ex_add", F_EXC, EX_ADD);
        want("lu_wb_ctl", F_WBC, 6);
        want("lu_wb_rd", F_WBRD, 5);
        want("lu_stall_keep", F_STALL, 1);
        // Register 0 compares like any other
        ins(EX_LW, MC_LW, 0, 1, 2);
        ins(EX_ADD, MC_ADD, 9, 1, 0);
        want("r0_pcw", F_PCW, 0);
        ins(EX_ADD, MC_ADD, 9, 1, 0);
        want("r0_resume", F_PCW, 1);
        want("r0_stall", F_STALL, 2);

        // BRZ taken
        rst_cycle(1);
        ins(EX_BR, MC_BRZ, 3, 1, 2);
        drive(1, EX_ADD, MC_ADD, 9, 1, 2, 1, 0, 1, 0);
        want("bz_ex_ctl", F_EXC, EX_BR);
        want("bz_no_red", F_RED, 0);
        ins(EX_ADD, MC_ADD, 10, 1, 2);
        want("bz_red", F_RED, 1);
        want("bz_src", F_SRC, 3);
        want("bz_flush", F_FLUSH, 1);
        want("bz_pcw", F_PCW, 1);
        want("bz_memc", F_MEMC, MC_BRZ);
        idle(1);
        want("bz_ex_bubble", F_EXC, 0);
        want("bz_mem_bubble", F_MEMC, 0);
        want("bz_rw_bubble", F_RW, 0);
        want("bz_red_clr", F_RED, 0);
        want("bz_flush_clr", F_FLUSH, 0);
        want("bz_wb_rd", F_WBRD, 3);

        // BRN not taken (n=0, z=1 irrelevant)
        rst_cycle(1);
        ins(EX_BR, MC_BRN, 4, 1, 2);
        drive(1, EX_ADD, MC_ADD, 11, 1, 2, 1, 0, 1, 0);
        ins(EX_ADD, MC_ADD, 12, 1, 2);
        want("bn_red", F_RED, 0);
        want("bn_flush", F_FLUSH, 0);
        want("bn_src", F_SRC, 0);
        want("bn_memc", F_MEMC, MC_BRN);
        want("bn_ex_ctl", F_EXC, EX_ADD);
        idle(1);
        want("bn_memc_next", F_MEMC, MC_ADD);
        want("bn_wb_rd", F_WBRD, 4);
        want("bn_ex_next", F_EXC, EX_ADD);
        idle(1);
        want("bn_wb_rd2", F_WBRD, 11);

        // Store freeze, 3 not-ready cycles
        rst_cycle(1);
        ins(EX_ADD, MC_ADD, 20, 1, 2);
        ins(EX_SW, MC_SW, 0, 2, 3);
        ins(EX_ADD, MC_ADD, 13, 6, 7);
        drive(1, EX_ADD, MC_ADD, 14, 1, 2, 0, 0, 0, 0);
        want("st_pcw0", F_PCW, 0);
        want("st_ifw0", F_IFW, 0);
        want("st_wb_rd", F_WBRD, 20);
        want("st_wb_ctl", F_WBC, 4);
        want("st_rw", F_RW, 1);
        want("st_red", F_RED, 0);
        drive(1, EX_ADD, MC_ADD, 14, 1, 2, 0, 0, 0, 0);
        want("st_wb_bubble1", F_WBC, 0);
        want("st_wb_rd_bubble", F_WBRD, 0);
        want("st_ex_hold", F_EXC, EX_ADD);
        want("st_pcw1", F_PCW, 0);
        want("st_stall1", F_STALL, 1);
        drive(1, EX_ADD, MC_ADD, 14, 1, 2, 0, 0, 0, 0);
        want("st_wb_bubble2", F_WBC, 0);
        want("st_stall2", F_STALL, 2);
        want("st_rw_hold", F_RW, 1);
        drive(1, EX_ADD, MC_ADD, 14, 1, 2, 0, 0, 1, 0);
        want("st_resume", F_PCW, 1);
        want("st_stall3", F_STALL, 3);
        want("st_wb_bubble3", F_WBC, 0);
        want("st_no_err", F_ERR, 0);
        idle(1);
        want("st_memc_adv", F_MEMC, MC_ADD);
        want("st_ex_adv", F_EXC, EX_ADD);
        want("st_rw_adv", F_RW, 0);
        want("st_stall_keep", F_STALL, 3);

        // Timeout: 6 not-ready cycles with MEM_TIMEOUT=4
        rst_cycle(1);
        ins(EX_LW, MC_LW, 8, 1, 2);
        idle(1);
        for (int i = 0; i < 6; i++) begin
            idle(0);
            want($sformatf("to_err_%0d", i), F_ERR, int'(i >= 4));
            want($sformatf("to_pcw_%0d", i), F_PCW, 0);
        end
        idle(1);
        want("to_err_sticky", F_ERR, 1);
        want("to_stall", F_STALL, 6);
        want("to_resume", F_PCW, 1);
        idle(1);
        want("to_err_sticky2", F_ERR, 1);
        want("to_wb_rd", F_WBRD, 8);
        want("to_wb_ctl", F_WBC, 6);

        // stall_cnt saturation at 3 bits
        rst_cycle(1);
        ins(EX_LW, MC_LW, 8, 1, 2);
        idle(1);
        for (int i = 0; i < 9; i++) idle(0);
        idle(1);
        want("sat_stall", F_STALL, 7);

        // Jump vs load-use in the same cycle: redirect wins
        rst_cycle(1);
        ins(EX_JMP, MC_JMP, 31, 1, 2);
        ins(EX_LW, MC_LW, 5, 1, 2);
        ins(EX_ADD, MC_ADD, 7, 5, 3);
        want("rl_red", F_RED, 1);
        want("rl_src", F_SRC, 1);
        want("rl_pcw", F_PCW, 1);
        want("rl_ifw", F_IFW, 1);
        want("rl_flush", F_FLUSH, 1);
        ins(EX_ADD, MC_ADD, 7, 5, 3);
        want("rl_pcw_next", F_PCW, 1);
        want("rl_stall", F_STALL, 0);
        want("rl_ex_bubble", F_EXC, 0);
        want("rl_wb_ctl", F_WBC, 1);
        want("rl_wb_rd", F_WBRD, 31);

        // JumpMem with memory ready
        rst_cycle(1);
        ins(EX_LW, MC_JMEM, 2, 1, 2);
        idle(1);
        idle(1);
        want("jm_red", F_RED, 1);
        want("jm_src", F_SRC, 2);
        want("jm_pcw", F_PCW, 1);

        // Reset during MEM_WAIT with JumpMem pending
        rst_cycle(1);
        ins(EX_LW, MC_JMEM, 2, 1, 2);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            idle(0);
            want($sformatf("mw_red_%0d", i), F_RED, 0);
            want($sformatf("mw_pcw_%0d", i), F_PCW, 0);
        end
        want("mw_err_before_reset", F_ERR, 1);
        rst_cycle(0);
        idle(1);
        want_reset_state("mw_rst");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
